pipe_stage_skid_reg: RTL and testbench
======================================

Name: pipe_stage_skid_reg

Overview:
Parametrised pipeline-stage register for the pipelined CPU datapath. It is the generalised successor of the fixed ID/EX-style latch. It carries a control field and a data field between stages under a valid/ready handshake. A one-entry skid buffer gives full throughput with a registered ready. The block adds synchronous flush (bubble insertion) and saturating stall and bubble performance counters.

Parameters:
DATA_W, 128, width of the data payload (operands, PC+4, immediates, instruction fields).
CTRL_W, 12, width of the control payload (RegWrite, MemRead, ALUOp, ...).
CTRL_BUBBLE, {CTRL_W{1'b0}}, control value presented whenever the stage holds no valid beat (a NOP).
CNT_W, 16, width of each performance counter.

Ports:
clk_i  in  1  clock, rising edge.
rst_n  in  1  reset, asynchronous, active-low.
flush_i  in  1  synchronous flush: discard all held beats plus any beat offered this cycle.
up_valid_i  in  1  upstream beat valid.
up_ready_o  out  1  stage can accept a beat.
up_ctrl_i  in  CTRL_W  upstream control payload.
up_data_i  in  DATA_W  upstream data payload.
dn_valid_o  out  1  downstream beat valid.
dn_ready_i  in  1  downstream accepts the beat.
dn_ctrl_o  out  CTRL_W  downstream control payload.
dn_data_o  out  DATA_W  downstream data payload.
cnt_clr_i  in  1  synchronous clear of both counters.
stall_cnt_o  out  CNT_W  cycles with dn_valid_o=1 and dn_ready_i=0.
bubble_cnt_o  out  CNT_W  cycles with dn_valid_o=0 and dn_ready_i=1.

Behaviour:
- Reset is asynchronous and active-low on rst_n, clock clk_i. During and after reset:
  - state EMPTY; dn_valid_o=0; up_ready_o=1;
  - main and skid ctrl registers = CTRL_BUBBLE; main and skid data registers = 0;
  - both counters = 0.
- Handshake definitions: up_acc = up_valid_i & up_ready_o; dn_acc = dn_valid_o & dn_ready_i.
- State encoding:
  - EMPTY: no entry valid.
  - FULL: main entry valid.
  - SKID: main and skid entries valid; skid is always the younger beat.
- Output decode, all from registers only (no combinational path from any input):
  - up_ready_o = (state != SKID).
  - dn_valid_o = (state != EMPTY).
  - dn_ctrl_o = main_ctrl.
  - dn_data_o = main_data.
- Transitions when flush_i=0:
  - EMPTY, up_acc: main<=up; go FULL.
  - EMPTY, no up_acc: stay EMPTY.
  - FULL, up_acc and dn_acc: main<=up; stay FULL.
  - FULL, up_acc and no dn_acc: skid<=up; go SKID.
  - FULL, dn_acc and no up_acc: main_ctrl<=CTRL_BUBBLE; go EMPTY.
  - FULL, neither: hold.
  - SKID, dn_acc: main<=skid; skid_ctrl<=CTRL_BUBBLE; go FULL.
  - SKID, no dn_acc: hold. up_ready_o is 0, so no up_acc is possible.
- Flush:
  - flush_i=1 overrides every transition: next state EMPTY; main_ctrl and skid_ctrl <= CTRL_BUBBLE.
  - An upstream beat offered in the flush cycle is dropped.
  - A dn_acc in the flush cycle still completes, since the consumer sampled the outputs that cycle.
  - Data registers are not cleared on flush.
  - Counters are unaffected by flush.
- Ctrl invariant: dn_ctrl_o equals CTRL_BUBBLE whenever dn_valid_o=0.
- Latency and throughput:
  - Latency is 1 cycle from up_acc in EMPTY to dn_valid_o=1.
  - Sustained 1 beat/cycle while dn_ready_i=1.
  - Beat order is strictly FIFO; no beat is duplicated or lost except by flush.
- Protocol guarantees:
  - dn_valid_o never falls, and dn_ctrl_o/dn_data_o never change, while dn_valid_o=1 and dn_ready_i=0, except on flush.
  - The upstream source must hold its payload while up_valid_i=1 and up_ready_o=0.
- Counters:
  - Increment under the conditions listed in Ports.
  - Saturate at 2^CNT_W-1; no wrap.
  - cnt_clr_i has priority over increment, giving value 0 in the next cycle.
- Reset mid-operation: all held beats are discarded immediately and outputs take their reset values asynchronously.

Test Plan:
- Streaming: dn_ready_i=1, beats D0..D9 offered back-to-back. Each appears on dn_data_o one cycle after acceptance, in order; up_ready_o stays 1; both counters stay 0.
- Backpressure fill: dn_ready_i=0, offer A then B then C.
  - A is held on the outputs; B goes to skid; up_ready_o=0 while C waits.
  - Raising dn_ready_i drains A, then B, then C with no loss or duplication.
  - stall_cnt_o equals the number of blocked cycles.
- Flush in SKID: state SKID with A/B, assert flush_i with C offered and dn_ready_i=0.
  - Next cycle: dn_valid_o=0, dn_ctrl_o=CTRL_BUBBLE, up_ready_o=1.
  - A, B and C are never delivered.
- Flush with concurrent dn_acc: state FULL holding A, dn_ready_i=1, flush_i=1. A counts as delivered; next cycle the state is EMPTY.
- Counter saturation: CNT_W=4, dn_ready_i=1 with idle input for 20 cycles.
  - bubble_cnt_o sticks at 15.
  - cnt_clr_i for one cycle gives 0 on the next cycle; counting then resumes.
- Asynchronous reset mid-SKID: pulse rst_n low between clock edges. Outputs go immediately to dn_valid_o=0, up_ready_o=1, dn_data_o=0, counters=0.

Source files
------------

// File: rtl/pipe_stage_skid_reg.sv
// pipe_stage_skid_reg
//   Pipeline-stage register with a valid/ready handshake and a one-entry skid
//   buffer. The skid buffer lets up_ready_o be driven from a register and
//   still sustain one beat per cycle. A synchronous flush turns the stage
//   into a bubble. Two saturating counters record stall cycles and bubble
//   cycles.
//
// Ports
//   clk_i         clock, rising edge
//   rst_n         asynchronous active-low reset
//   flush_i       drop all held beats and the beat offered this cycle
//   up_valid_i    upstream beat valid
//   up_ready_o    stage can accept a beat (registered)
//   up_ctrl_i     upstream control payload
//   up_data_i     upstream data payload
//   dn_valid_o    downstream beat valid (registered)
//   dn_ready_i    downstream accepts the beat
//   dn_ctrl_o     downstream control payload, CTRL_BUBBLE when not valid
//   dn_data_o     downstream data payload
//   cnt_clr_i     synchronous clear of both counters
//   stall_cnt_o   cycles with dn_valid_o=1 and dn_ready_i=0 (saturating)
//   bubble_cnt_o  cycles with dn_valid_o=0 and dn_ready_i=1 (saturating)

module pipe_stage_skid_reg #(
    parameter int unsigned            DATA_W      = 128,
    parameter int unsigned            CTRL_W      = 12,
    parameter logic [CTRL_W-1:0]      CTRL_BUBBLE = '0,
    parameter int unsigned            CNT_W       = 16
) (
    input  logic              clk_i,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              up_valid_i,
    output logic              up_ready_o,
    input  logic [CTRL_W-1:0] up_ctrl_i,
    input  logic [DATA_W-1:0] up_data_i,
    output logic              dn_valid_o,
    input  logic              dn_ready_i,
    output logic [CTRL_W-1:0] dn_ctrl_o,
    output logic [DATA_W-1:0] dn_data_o,
    input  logic              cnt_clr_i,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  bubble_cnt_o
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_e;

    state_e            state_q;
    logic [CTRL_W-1:0] main_ctrl_q;
    logic [DATA_W-1:0] main_data_q;
    logic [CTRL_W-1:0] skid_ctrl_q;
    logic [DATA_W-1:0] skid_data_q;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic [CNT_W-1:0]  stall_cnt_d;
    logic [CNT_W-1:0]  bubble_cnt_q;
    logic [CNT_W-1:0]  bubble_cnt_d;

    logic up_acc;
    logic dn_acc;

    // All outputs decode from registers only.
    assign up_ready_o   = (state_q != SKID);
    assign dn_valid_o   = (state_q != EMPTY);
    assign dn_ctrl_o    = main_ctrl_q;
    assign dn_data_o    = main_data_q;
    assign stall_cnt_o  = stall_cnt_q;
    assign bubble_cnt_o = bubble_cnt_q;

    assign up_acc = up_valid_i & up_ready_o;
    assign dn_acc = dn_valid_o & dn_ready_i;

    // Main entry always holds the oldest beat; skid holds the younger one.
    // Ctrl of an invalid entry is forced to CTRL_BUBBLE so the downstream
    // stage sees a NOP whenever dn_valid_o is low. Data is left untouched.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            main_ctrl_q <= CTRL_BUBBLE;
            main_data_q <= '0;
            skid_ctrl_q <= CTRL_BUBBLE;
            skid_data_q <= '0;
        end else if (flush_i) begin
            // A concurrent dn_acc needs no action: the consumer already
            // sampled the beat this cycle.
            state_q     <= EMPTY;
            main_ctrl_q <= CTRL_BUBBLE;
            skid_ctrl_q <= CTRL_BUBBLE;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (up_acc) begin
                        main_ctrl_q <= up_ctrl_i;
                        main_data_q <= up_data_i;
                        state_q     <= FULL;
                    end
                end
                FULL: begin
                    if (up_acc && dn_acc) begin
                        main_ctrl_q <= up_ctrl_i;
                        main_data_q <= up_data_i;
                    end else if (up_acc) begin
                        skid_ctrl_q <= up_ctrl_i;
                        skid_data_q <= up_data_i;
                        state_q     <= SKID;
                    end else if (dn_acc) begin
                        main_ctrl_q <= CTRL_BUBBLE;
                        state_q     <= EMPTY;
                    end
                end
                SKID: begin
                    if (dn_acc) begin
                        main_ctrl_q <= skid_ctrl_q;
                        main_data_q <= skid_data_q;
                        skid_ctrl_q <= CTRL_BUBBLE;
                        state_q     <= FULL;
                    end
                end
                default: begin
                    state_q <= EMPTY;
                end
            endcase
        end
    end

    // Saturating performance counters; clear wins over increment.
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (cnt_clr_i) begin
            stall_cnt_d  = '0;
            bubble_cnt_d = '0;
        end else begin
            if (dn_valid_o && !dn_ready_i && (stall_cnt_q != '1)) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
            if (!dn_valid_o && dn_ready_i && (bubble_cnt_q != '1)) begin
                bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// tb_pipe_stage_skid_reg
//   Directed bench for pipe_stage_skid_reg. A table of cycle vectors
//   (inputs for one cycle plus the outputs expected after that clock edge)
//   covers streaming and backpressure; further vectors and hand-written
//   steps cover flush, counter saturation/clear and asynchronous reset.

module tb_pipe_stage_skid_reg;

    localparam int unsigned     DATA_W = 16;
    localparam int unsigned     CTRL_W = 4;
    localparam int unsigned     CNT_W  = 4;
    localparam logic [CTRL_W-1:0] BUB  = 4'hA;

    logic              clk_i = 1'b0;
    logic              rst_n;
    logic              flush_i;
    logic              up_valid_i;
    logic              up_ready_o;
    logic [CTRL_W-1:0] up_ctrl_i;
    logic [DATA_W-1:0] up_data_i;
    logic              dn_valid_o;
    logic              dn_ready_i;
    logic [CTRL_W-1:0] dn_ctrl_o;
    logic [DATA_W-1:0] dn_data_o;
    logic              cnt_clr_i;
    logic [CNT_W-1:0]  stall_cnt_o;
    logic [CNT_W-1:0]  bubble_cnt_o;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    always #5 clk_i = ~clk_i;

    pipe_stage_skid_reg #(
        .DATA_W      (DATA_W),
        .CTRL_W      (CTRL_W),
        .CTRL_BUBBLE (BUB),
        .CNT_W       (CNT_W)
    ) dut (
        .clk_i        (clk_i),
        .rst_n        (rst_n),
        .flush_i      (flush_i),
        .up_valid_i   (up_valid_i),
        .up_ready_o   (up_ready_o),
        .up_ctrl_i    (up_ctrl_i),
        .up_data_i    (up_data_i),
        .dn_valid_o   (dn_valid_o),
        .dn_ready_i   (dn_ready_i),
        .dn_ctrl_o    (dn_ctrl_o),
        .dn_data_o    (dn_data_o),
        .cnt_clr_i    (cnt_clr_i),
        .stall_cnt_o  (stall_cnt_o),
        .bubble_cnt_o (bubble_cnt_o)
    );

    typedef struct {
        logic              flush;
        logic              up_v;
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] data;
        logic              rdy;
        logic              clr;
        logic              e_valid;
        logic              e_urdy;
        logic [CTRL_W-1:0] e_ctrl;
        logic [DATA_W-1:0] e_data;
        logic [CNT_W-1:0]  e_stall;
        logic [CNT_W-1:0]  e_bubble;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic flush, input logic up_v, input logic [CTRL_W-1:0] ctrl,
        input logic [DATA_W-1:0] data, input logic rdy, input logic clr,
        input logic e_valid, input logic e_urdy, input logic [CTRL_W-1:0] e_ctrl,
        input logic [DATA_W-1:0] e_data, input logic [CNT_W-1:0] e_stall,
        input logic [CNT_W-1:0] e_bubble);
        vec_t v;
        v.flush = flush;     v.up_v = up_v;     v.ctrl = ctrl;
        v.data = data;       v.rdy = rdy;       v.clr = clr;
        v.e_valid = e_valid; v.e_urdy = e_urdy; v.e_ctrl = e_ctrl;
        v.e_data = e_data;   v.e_stall = e_stall; v.e_bubble = e_bubble;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, clock it, then check outputs 1 time unit later.
    task automatic apply(input vec_t v, input string tag);
        flush_i    = v.flush;
        up_valid_i = v.up_v;
        up_ctrl_i  = v.ctrl;
        up_data_i  = v.data;
        dn_ready_i = v.rdy;
        cnt_clr_i  = v.clr;
        @(posedge clk_i);
        #1;
        chk({tag, " dn_valid"}, 32'(dn_valid_o),   32'(v.e_valid));
        chk({tag, " up_ready"}, 32'(up_ready_o),   32'(v.e_urdy));
        chk({tag, " dn_ctrl"},  32'(dn_ctrl_o),    32'(v.e_ctrl));
        chk({tag, " dn_data"},  32'(dn_data_o),    32'(v.e_data));
        chk({tag, " stall"},    32'(stall_cnt_o),  32'(v.e_stall));
        chk({tag, " bubble"},   32'(bubble_cnt_o), 32'(v.e_bubble));
    endtask

    initial begin
        flush_i = 0; up_valid_i = 0; up_ctrl_i = '0; up_data_i = '0;
        dn_ready_i = 0; cnt_clr_i = 0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("reset dn_valid", 32'(dn_valid_o),   32'd0);
        chk("reset up_ready", 32'(up_ready_o),   32'd1);
        chk("reset dn_ctrl",  32'(dn_ctrl_o),    32'(BUB));
        chk("reset dn_data",  32'(dn_data_o),    32'd0);
        chk("reset stall",    32'(stall_cnt_o),  32'd0);
        chk("reset bubble",   32'(bubble_cnt_o), 32'd0);
        #19 rst_n = 1'b1;
        @(posedge clk_i);
        #1;

        // Streaming D0..D9: first beat offered with dn_ready low so no bubble
        // is counted; afterwards one beat per cycle.
        vecs.push_back(mk(0, 1, 4'h0, 16'h1000, 0, 0, 1, 1, 4'h0, 16'h1000, 0, 0));
        for (int k = 1; k < 10; k++)
            vecs.push_back(mk(0, 1, 4'(k), 16'(16'h1000 + k), 1, 0,
                              1, 1, 4'(k), 16'(16'h1000 + k), 0, 0));
        vecs.push_back(mk(0, 0, 4'h0, 16'h0000, 1, 0, 0, 1, BUB, 16'h1009, 0, 0));
        // Backpressure: A held, B into skid, C waits, then drain A,B,C.
        vecs.push_back(mk(0, 1, 4'h3, 16'hAAAA, 0, 0, 1, 1, 4'h3, 16'hAAAA, 0, 0));
        vecs.push_back(mk(0, 1, 4'h5, 16'hBBBB, 0, 0, 1, 0, 4'h3, 16'hAAAA, 1, 0));
        vecs.push_back(mk(0, 1, 4'h6, 16'hCCCC, 0, 0, 1, 0, 4'h3, 16'hAAAA, 2, 0));
        vecs.push_back(mk(0, 1, 4'h6, 16'hCCCC, 0, 0, 1, 0, 4'h3, 16'hAAAA, 3, 0));
        vecs.push_back(mk(0, 1, 4'h6, 16'hCCCC, 1, 0, 1, 1, 4'h5, 16'hBBBB, 3, 0));
        vecs.push_back(mk(0, 1, 4'h6, 16'hCCCC, 1, 0, 1, 1, 4'h6, 16'hCCCC, 3, 0));
        vecs.push_back(mk(0, 0, 4'h0, 16'h0000, 1, 0, 0, 1, BUB, 16'hCCCC, 3, 0));
        vecs.push_back(mk(0, 0, 4'h0, 16'h0000, 0, 0, 0, 1, BUB, 16'hCCCC, 3, 0));
        // Flush in SKID holding A2/B2 with C2 offered and dn_ready low;
        // none of them may ever appear downstream.
        vecs.push_back(mk(0, 1, 4'h7, 16'h1111, 0, 0, 1, 1, 4'h7, 16'h1111, 3, 0));
        vecs.push_back(mk(0, 1, 4'h8, 16'h2222, 0, 0, 1, 0, 4'h7, 16'h1111, 4, 0));
        vecs.push_back(mk(1, 1, 4'h9, 16'h3333, 0, 0, 0, 1, BUB, 16'h1111, 5, 0));
        vecs.push_back(mk(0, 0, 4'h0, 16'h0000, 1, 0, 0, 1, BUB, 16'h1111, 5, 1));
        vecs.push_back(mk(0, 0, 4'h0, 16'h0000, 1, 0, 0, 1, BUB, 16'h1111, 5, 2));
        vecs.push_back(mk(0, 0, 4'h0, 16'h0000, 1, 0, 0, 1, BUB, 16'h1111, 5, 3));
        // Flush with concurrent dn_acc: A3 is consumed in the flush cycle,
        // then the stage is empty and does not present A3 again.
        vecs.push_back(mk(0, 1, 4'h4, 16'h4444, 0, 0, 1, 1, 4'h4, 16'h4444, 5, 3));
        vecs.push_back(mk(1, 0, 4'h0, 16'h0000, 1, 0, 0, 1, BUB, 16'h4444, 5, 3));
        vecs.push_back(mk(0, 0, 4'h0, 16'h0000, 1, 0, 0, 1, BUB, 16'h4444, 5, 4));

        foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

        // Bubble counter saturation at 15, then clear and resume.
        for (int i = 0; i < 20; i++) begin
            int unsigned eb;
            eb = (5 + i > 15) ? 15 : 5 + i;
            apply(mk(0, 0, 4'h0, 16'h0000, 1, 0, 0, 1, BUB, 16'h4444, 5, 4'(eb)),
                  $sformatf("sat%0d", i));
        end
        apply(mk(0, 0, 4'h0, 16'h0000, 1, 1, 0, 1, BUB, 16'h4444, 0, 0), "clr");
        apply(mk(0, 0, 4'h0, 16'h0000, 1, 0, 0, 1, BUB, 16'h4444, 0, 1), "resume");

        // Asynchronous reset in the middle of a cycle while in SKID.
        apply(mk(0, 1, 4'h1, 16'h5555, 0, 0, 1, 1, 4'h1, 16'h5555, 0, 1), "ar_fill0");
        apply(mk(0, 1, 4'h2, 16'h6666, 0, 0, 1, 0, 4'h1, 16'h5555, 1, 1), "ar_fill1");
        #2 rst_n = 1'b0;
        #1;
        chk("async dn_valid", 32'(dn_valid_o),   32'd0);
        chk("async up_ready", 32'(up_ready_o),   32'd1);
        chk("async dn_ctrl",  32'(dn_ctrl_o),    32'(BUB));
        chk("async dn_data",  32'(dn_data_o),    32'd0);
        chk("async stall",    32'(stall_cnt_o),  32'd0);
        chk("async bubble",   32'(bubble_cnt_o), 32'd0);
        #2 rst_n = 1'b1;
        apply(mk(0, 1, 4'h3, 16'h7777, 0, 0, 1, 1, 4'h3, 16'h7777, 0, 0), "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
